card_dealer: RTL and testbench
==============================

# card_dealer

Card source that answers the hand-accumulation ALU's card requests. It holds one 52-card deck as a dealt-card bitmap and picks an undealt card at pseudo-random using a free-running LFSR. Each pick is returned as a blackjack value on `card_value` with a one-cycle `card_ready` strobe. It sits between the game FSM, which issues `deal_req`/`shuffle`, and the ALU, which consumes `card_value`/`card_ready`.

## Interface
- `SEED`, 16'hACE1, LFSR reset value; 16'h0000 is illegal and is replaced by 16'h0001.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `shuffle`  in  1  return all 52 cards to the deck; wins over `deal_req` in the same cycle.
- `deal_req`  in  1  request one card; sampled only in IDLE; a request seen in any other state is dropped.
- `card_value`  out  4  blackjack value of the last card: 2–10, face cards = 10, Ace = 11.
- `card_rank`  out  4  rank of the last card: 1 = Ace … 13 = King.
- `card_ready`  out  1  one-cycle strobe; `card_value`/`card_rank` are valid from this cycle onward.
- `busy`  out  1  high while the block is searching for a card.
- `deal_err`  out  1  one-cycle strobe; the deck was empty when a request arrived.
- `deck_empty`  out  1  high when `cards_left == 0`.
- `cards_left`  out  6  undealt cards remaining, 0–52.

## Operation
- **LFSR.** 16-bit Galois, x^16+x^14+x^13+x^11+1.
  - Update: `lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0)`.
  - Advances every cycle except reset. `shuffle` does not reseed it.
- **Card index.** idx 0–51; suit = idx/13, rank = (idx mod 13) + 1.
  - Value: rank 1 → 11; ranks 2–10 → rank; ranks 11–13 → 10.
- **FSM states:** IDLE, PROBE.
- **IDLE**
  - `deal_req=1` and `cards_left>0`: load idx = `lfsr[5:0]`, minus 52 if ≥ 52 (range 0–51); go to PROBE.
  - `deal_req=1` and `cards_left==0`: pulse `deal_err`, stay in IDLE, no `card_ready`.
- **PROBE**, one bitmap probe per cycle:
  - `dealt[idx]==0` (hit):
    - set `dealt[idx]`
    - register `card_value`/`card_rank` from idx
    - decrement `cards_left`
    - pulse `card_ready`
    - go to IDLE.
  - `dealt[idx]==1` (miss): idx = (idx==51) ? 0 : idx+1; stay in PROBE.
  - The search always terminates, because PROBE is entered only with `cards_left>0`.
- **shuffle** (any state):
  - clear the bitmap, `cards_left <= 52`, state ← IDLE
  - suppress `card_ready`/`deal_err` in that cycle
  - `card_value`/`card_rank` keep their old values
  - an in-flight deal is aborted with no strobe.
- **`deal_req` is level-sensitive in IDLE.** Upstream must drive a single-cycle pulse per card; a held level deals again after each delivery.
- **`card_value`/`card_rank`** hold their value until the next hit.

## Timing
- **Reset values:**
  - state IDLE, bitmap clear, `cards_left=52`
  - `card_value=0`, `card_rank=0`
  - `card_ready=0`, `busy=0`, `deal_err=0`, `deck_empty=0`
  - `lfsr=SEED`.
- **Reset mid-PROBE:** aborts the search; no `card_ready`; all outputs go to their reset values on the next cycle.
- **Latency:** with `deal_req` sampled at edge E0, `card_ready` is high in the cycle after edge E0+k, where k = probes needed.
  - Minimum: k=1, so `card_ready` is high 2 cycles after `deal_req` is asserted.
  - Worst case: k=52 (51 cards already dealt).
- **busy** is registered: high from the cycle after the request is accepted until the cycle `card_ready` is high; low in that cycle.
- **deal_err** is high in the cycle after the rejected request is sampled.
- **ALU compatibility:** `card_ready` is never high in the cycle a request is accepted, so the consumer always latches its pending flag before the card arrives.
- **cards_left, deck_empty** update in the same cycle as `card_ready`.

## Test plan
- **Reset:** `rst` for 2 cycles → `cards_left=52`, `card_ready=0`, `busy=0`, `card_value=0`, `deck_empty=0`.
- **Full deck:** `shuffle`, then 52 single-cycle `deal_req` pulses, each issued after the previous `card_ready`. Required:
  - exactly 52 `card_ready` strobes
  - each rank 1–13 appears exactly 4 times
  - sum of `card_value` = 380
  - no idx repeats
  - final `cards_left=0`, `deck_empty=1`.
- **Empty deck:** 53rd `deal_req` → `deal_err` high for 1 cycle, no `card_ready`, `busy=0`, `cards_left` stays 0.
- **Latency bounds:** every delivery shows latency ≥ 2 and ≤ 53 cycles. Force the 52nd card to idx 0 via bitmap preload → probe wraps 51→0 and the card has `card_rank=1`, `card_value=11`.
- **Shuffle mid-search:** assert `shuffle` while `busy=1` → next cycle `busy=0`, `cards_left=52`, no `card_ready`, `card_value` unchanged. Assert `shuffle` and `deal_req` in the same cycle → request ignored.
- **Dropped request:** `deal_req` pulsed while `busy=1` → exactly one `card_ready`, `cards_left` decremented by 1.

Source files
------------

// File: rtl/card_dealer.sv
// rtl/card_dealer.sv - 52-card dealer: dealt-card bitmap, LFSR pick, linear probe to the next undealt card.

module card_dealer_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] lfsr
);
  // An all-zero Galois LFSR never leaves zero, so that seed is replaced.
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  end

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= SEED_EFF;
    else     lfsr_q <= lfsr_d;
  end

  assign lfsr = lfsr_q;
endmodule

module card_dealer #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       shuffle,
  input  logic       deal_req,
  output logic [3:0] card_value,
  output logic [3:0] card_rank,
  output logic       card_ready,
  output logic       busy,
  output logic       deal_err,
  output logic       deck_empty,
  output logic [5:0] cards_left
);
  typedef enum logic {IDLE, PROBE} state_t;

  state_t      state_q, state_d;
  logic [51:0] dealt_q, dealt_d;
  logic [5:0]  idx_q, idx_d;
  logic [5:0]  cards_left_q, cards_left_d;
  logic [3:0]  card_value_q, card_value_d;
  logic [3:0]  card_rank_q, card_rank_d;
  logic        card_ready_q, card_ready_d;
  logic        busy_q, busy_d;
  logic        deal_err_q, deal_err_d;

  logic [15:0] lfsr;
  logic [5:0]  start_idx;
  logic [5:0]  rem;
  logic [3:0]  rank;
  logic [3:0]  value;

  card_dealer_lfsr #(.SEED(SEED)) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .lfsr (lfsr)
  );

  always_comb begin
    start_idx = (lfsr[5:0] >= 6'd52) ? (lfsr[5:0] - 6'd52) : lfsr[5:0];
  end

  // Rank and blackjack value of the card currently under the probe.
  always_comb begin
    if (idx_q >= 6'd39)      rem = idx_q - 6'd39;
    else if (idx_q >= 6'd26) rem = idx_q - 6'd26;
    else if (idx_q >= 6'd13) rem = idx_q - 6'd13;
    else                     rem = idx_q;
    rank = rem[3:0] + 4'd1;
    if (rank == 4'd1)       value = 4'd11;
    else if (rank > 4'd10)  value = 4'd10;
    else                    value = rank;
  end

  always_comb begin
    state_d      = state_q;
    dealt_d      = dealt_q;
    idx_d        = idx_q;
    cards_left_d = cards_left_q;
    card_value_d = card_value_q;
    card_rank_d  = card_rank_q;
    card_ready_d = 1'b0;
    deal_err_d   = 1'b0;

    if (shuffle) begin
      dealt_d      = '0;
      cards_left_d = 6'd52;
      state_d      = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (deal_req) begin
            if (cards_left_q != 6'd0) begin
              idx_d   = start_idx;
              state_d = PROBE;
            end else begin
              deal_err_d = 1'b1;
            end
          end
        end
        PROBE: begin
          if (!dealt_q[idx_q]) begin
            dealt_d[idx_q] = 1'b1;
            card_value_d   = value;
            card_rank_d    = rank;
            cards_left_d   = cards_left_q - 6'd1;
            card_ready_d   = 1'b1;
            state_d        = IDLE;
          end else begin
            idx_d = (idx_q == 6'd51) ? 6'd0 : (idx_q + 6'd1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d == PROBE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      dealt_q      <= '0;
      idx_q        <= 6'd0;
      cards_left_q <= 6'd52;
      card_value_q <= 4'd0;
      card_rank_q  <= 4'd0;
      card_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      deal_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      dealt_q      <= dealt_d;
      idx_q        <= idx_d;
      cards_left_q <= cards_left_d;
      card_value_q <= card_value_d;
      card_rank_q  <= card_rank_d;
      card_ready_q <= card_ready_d;
      busy_q       <= busy_d;
      deal_err_q   <= deal_err_d;
    end
  end

  assign card_value = card_value_q;
  assign card_rank  = card_rank_q;
  assign card_ready = card_ready_q;
  assign busy       = busy_q;
  assign deal_err   = deal_err_q;
  assign cards_left = cards_left_q;
  assign deck_empty = (cards_left_q == 6'd0);
endmodule

// File: tb/tb_card_dealer.sv
// tb/tb_card_dealer.sv - card_dealer bench: deck-level model checked every cycle plus directed literal checks.

module tb_card_dealer;
  logic       clk = 1'b0;
  logic       rst, shuffle, deal_req;
  logic [3:0] card_value, card_rank;
  logic       card_ready, busy, deal_err, deck_empty;
  logic [5:0] cards_left;

  int tests = 0;
  int fails = 0;

  card_dealer dut (
    .clk        (clk),
    .rst        (rst),
    .shuffle    (shuffle),
    .deal_req   (deal_req),
    .card_value (card_value),
    .card_rank  (card_rank),
    .card_ready (card_ready),
    .busy       (busy),
    .deal_err   (deal_err),
    .deck_empty (deck_empty),
    .cards_left (cards_left)
  );

  always #5 clk = ~clk;

  // Deck model: a pick is resolved when accepted; the card lands after k probe cycles.
  bit [15:0] m_lfsr;
  bit        m_dealt [52];
  int        m_left, m_count, m_pend, m_value, m_rank;
  bit        m_ready, m_err, m_started;

  int n_ready = 0;
  int sum_val = 0;
  int hist [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void pick(input bit [15:0] l, output int j, output int k);
    j = int'(l[5:0]);
    if (j >= 52) j -= 52;
    k = 1;
    while (m_dealt[j] && k <= 52) begin
      j = (j == 51) ? 0 : j + 1;
      k++;
    end
  endfunction

  function automatic int value_of(input int r);
    if (r == 1) return 11;
    if (r > 10) return 10;
    return r;
  endfunction

  always @(posedge clk) begin
    int j, k;
    m_started = 1'b1;
    m_ready   = 1'b0;
    m_err     = 1'b0;
    if (rst) begin
      foreach (m_dealt[i]) m_dealt[i] = 1'b0;
      m_left = 52; m_count = 0; m_value = 0; m_rank = 0;
      m_lfsr = 16'hACE1;
    end else begin
      if (shuffle) begin
        foreach (m_dealt[i]) m_dealt[i] = 1'b0;
        m_left = 52; m_count = 0;
      end else if (m_count > 0) begin
        m_count--;
        if (m_count == 0) begin
          m_dealt[m_pend] = 1'b1;
          m_rank  = m_pend % 13 + 1;
          m_value = value_of(m_rank);
          m_left--;
          m_ready = 1'b1;
        end
      end else if (deal_req) begin
        if (m_left > 0) begin
          pick(m_lfsr, j, k);
          m_pend  = j;
          m_count = k;
        end else begin
          m_err = 1'b1;
        end
      end
      m_lfsr = {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end
  end

  always @(negedge clk) begin
    if (m_started) begin
      chk("card_ready", card_ready, m_ready);
      chk("deal_err", deal_err, m_err);
      chk("busy", busy, m_count > 0);
      chk("cards_left", cards_left, m_left);
      chk("deck_empty", deck_empty, m_left == 0);
      chk("card_value", card_value, m_value);
      chk("card_rank", card_rank, m_rank);
      if (card_ready === 1'b1) begin
        n_ready++;
        sum_val += int'(card_value);
        if (card_rank <= 4'd13) hist[card_rank]++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int r0, s0, j, k, lat, guard;
    logic [3:0] saved;
    rst = 1'b1; shuffle = 1'b0; deal_req = 1'b0;
    foreach (hist[i]) hist[i] = 0;
    tick(); tick();
    chk("rst_cards_left", cards_left, 52);
    chk("rst_card_ready", card_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_card_value", card_value, 0);
    chk("rst_deck_empty", deck_empty, 0);
    rst = 1'b0;
    tick();

    // Shuffle while the first probe is pending aborts the deal.
    deal_req = 1'b1; tick(); deal_req = 1'b0;
    chk("mid_busy_before", busy, 1);
    saved = card_value;
    shuffle = 1'b1; tick(); shuffle = 1'b0;
    chk("mid_busy_after", busy, 0);
    chk("mid_cards_left", cards_left, 52);
    chk("mid_no_ready", card_ready, 0);
    chk("mid_value_kept", card_value, saved);

    shuffle = 1'b1; deal_req = 1'b1; tick(); shuffle = 1'b0; deal_req = 1'b0;
    chk("same_cycle_busy", busy, 0);
    chk("same_cycle_left", cards_left, 52);
    tick();
    chk("same_cycle_no_ready", card_ready, 0);

    // Request during PROBE is dropped.
    r0 = n_ready;
    deal_req = 1'b1; tick(); deal_req = 1'b0;
    deal_req = 1'b1; tick(); deal_req = 1'b0;
    repeat (6) tick();
    chk("dropped_one_ready", n_ready - r0, 1);
    chk("dropped_left", cards_left, 51);

    // Full deck, timed so idx 0 is the last card and is reached by wrapping 51->0.
    shuffle = 1'b1; tick(); shuffle = 1'b0;
    foreach (hist[i]) hist[i] = 0;
    r0 = n_ready; s0 = sum_val;
    for (int c = 0; c < 52; c++) begin
      guard = 0;
      forever begin
        pick(m_lfsr, j, k);
        if (c < 51 && j != 0) break;
        if (c == 51 && m_lfsr[5:0] != 6'd0 && m_lfsr[5:0] != 6'd52) break;
        tick();
        guard++;
        if (guard > 500) break;
      end
      if (guard > 500) begin
        tests++; fails++;
        $display("FAIL steer_timeout: got %0d cycles expected at most 500", guard);
      end
      deal_req = 1'b1; tick(); deal_req = 1'b0;
      lat = 0;
      forever begin
        @(negedge clk);
        lat++;
        if (card_ready === 1'b1 || lat > 60) break;
      end
      chk("latency_min_ok", lat >= 2, 1);
      chk("latency_max_ok", lat <= 53, 1);
      if (c == 51) begin
        chk("last_rank", card_rank, 1);
        chk("last_value", card_value, 11);
      end
      tick();
    end
    chk("deck_ready_count", n_ready - r0, 52);
    for (int r = 1; r <= 13; r++) chk("rank_hist", hist[r], 4);
    chk("deck_value_sum", sum_val - s0, 380);
    chk("deck_left", cards_left, 0);
    chk("deck_empty", deck_empty, 1);

    // Empty deck.
    r0 = n_ready;
    deal_req = 1'b1; tick(); deal_req = 1'b0;
    chk("empty_err", deal_err, 1);
    chk("empty_no_ready", card_ready, 0);
    chk("empty_busy", busy, 0);
    chk("empty_left", cards_left, 0);
    tick();
    chk("empty_err_one_cycle", deal_err, 0);
    chk("empty_no_card", n_ready - r0, 0);

    // Reset during PROBE.
    shuffle = 1'b1; tick(); shuffle = 1'b0;
    deal_req = 1'b1; tick(); deal_req = 1'b0;
    chk("rstmid_busy", busy, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rstmid_ready", card_ready, 0);
    chk("rstmid_busy_after", busy, 0);
    chk("rstmid_value", card_value, 0);
    chk("rstmid_left", cards_left, 52);
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
